// File: rtl/clf_pkg.sv
// Shared types and helpers for the AXI-Stream linear classifier.
// Frame geometry depends on instance parameters, so it is computed by functions the top evaluates.
package clf_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    READ_W = 4'b0010,
    READ_X = 4'b0100,
    WRITE  = 4'b1000
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_N_FEAT    = 7;
  localparam int DEF_N_SAMPLES = 64;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_THRESH    = 128;

  function automatic int frame_len(input int n_feat, input int n_samples);
    return n_feat + 1 + n_samples * n_feat;
  endfunction

  function automatic int weight_count(input int n_feat);
    return n_feat + 1;
  endfunction

  // A counter always needs at least one bit, even for a depth of one.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [31:0] format_score(input logic signed [31:0] score,
                                               input logic              raw,
                                               input logic signed [31:0] thresh);
    return raw ? score : {31'b0, score > thresh};
  endfunction

endpackage

// File: rtl/clf_result_buf.sv
// Result store: one score per sample, written during accumulation, read while streaming out.
module clf_result_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 24,
  parameter int AW    = 6
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_linear_classifier.sv
// Streaming linear classifier: loads a weight vector, scores each sample on the fly,
// then emits one class bit or raw score per sample on the master stream.
module axis_linear_classifier
  import clf_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_FEAT    = DEF_N_FEAT,
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int THRESH    = DEF_THRESH
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        MODE,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        ERR
);

  localparam int L      = frame_len(N_FEAT, N_SAMPLES);
  localparam int N_W    = weight_count(N_FEAT);
  localparam int SP_W   = ptr_w(N_SAMPLES);
  localparam int FP_W   = ptr_w(N_W);
  localparam int WC_W   = ptr_w(L);
  localparam int PROD_W = 2 * DATA_W + 1;

  state_t state, state_nxt;
  logic mode_raw, err;
  logic signed [DATA_W-1:0] w [N_W];
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic [ACC_W-1:0] rd_score;
  logic [FP_W-1:0] w_idx, f_idx;
  logic [SP_W-1:0] wr_ptr, rd_ptr;
  logic [WC_W-1:0] word_cnt;
  logic s_ready, m_valid, in_fire, out_fire;
  logic last_w, last_f, last_s, last_word, rd_last, early_last, buf_we;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W:0] x_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [31:0] score32;
  logic unused_bits;

  assign din         = S_AXIS_TDATA[DATA_W-1:0];
  assign x_s         = {1'b0, S_AXIS_TDATA[DATA_W-1:0]};
  assign unused_bits = ^S_AXIS_TDATA[31:DATA_W];

  // Features are unsigned, so widen by one zero bit before the signed multiply.
  assign prod    = x_s * w[f_idx];
  assign acc_sum = acc + ACC_W'(prod);

  assign s_ready  = (state == READ_W) || (state == READ_X);
  assign m_valid  = (state == WRITE);
  assign in_fire  = S_AXIS_TVALID & s_ready;
  assign out_fire = m_valid & M_AXIS_TREADY;

  assign last_w     = (w_idx == FP_W'(N_FEAT));
  assign last_f     = (f_idx == FP_W'(N_FEAT));
  assign last_s     = (wr_ptr == SP_W'(N_SAMPLES - 1));
  assign rd_last    = (rd_ptr == SP_W'(N_SAMPLES - 1));
  assign last_word  = (word_cnt == WC_W'(L - 1));
  assign early_last = in_fire & S_AXIS_TLAST & ~last_word;
  assign buf_we     = in_fire & (state == READ_X) & last_f & ~early_last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (S_AXIS_TVALID) state_nxt = READ_W;
      READ_W:  if (early_last) state_nxt = IDLE;
               else if (in_fire && last_w) state_nxt = READ_X;
      READ_X:  if (early_last) state_nxt = IDLE;
               else if (in_fire && last_word) state_nxt = WRITE;
      WRITE:   if (out_fire && rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      mode_raw <= 1'b0;
      err      <= 1'b0;
      acc      <= '0;
      w_idx    <= '0;
      f_idx    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      for (int i = 0; i < N_W; i++) w[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && S_AXIS_TVALID) mode_raw <= MODE;
      if (early_last || (in_fire && last_word && !S_AXIS_TLAST)) err <= 1'b1;
      // An early TLAST drops the partial frame; the next frame restarts from word one.
      if (early_last) begin
        word_cnt <= '0;
        w_idx    <= '0;
        f_idx    <= '0;
        wr_ptr   <= '0;
      end else if (in_fire) begin
        word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
        if (state == READ_W) begin
          w[w_idx] <= din;
          if (w_idx == '0) acc <= ACC_W'(din);
          w_idx <= last_w ? '0 : w_idx + FP_W'(1);
          f_idx <= FP_W'(1);
        end else if (last_f) begin
          acc    <= ACC_W'(w[0]);
          f_idx  <= FP_W'(1);
          wr_ptr <= last_s ? '0 : wr_ptr + SP_W'(1);
        end else begin
          acc   <= acc_sum;
          f_idx <= f_idx + FP_W'(1);
        end
      end
      if (out_fire) rd_ptr <= rd_last ? '0 : rd_ptr + SP_W'(1);
    end
  end

  clf_result_buf #(
    .DEPTH(N_SAMPLES),
    .WIDTH(ACC_W),
    .AW   (SP_W)
  ) u_result_buf (
    .clock  (ACLK),
    .we     (buf_we),
    .wr_addr(wr_ptr),
    .wr_data(acc_sum),
    .rd_addr(rd_ptr),
    .rd_data(rd_score)
  );

  assign score32       = 32'(signed'(rd_score));
  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TLAST  = m_valid & rd_last;
  assign M_AXIS_TDATA  = m_valid ? format_score(score32, mode_raw, 32'(THRESH)) : 32'b0;
  assign ERR           = err;

endmodule

// File: tb/tb_axis_linear_classifier.sv
// Directed bench for axis_linear_classifier with a small frame (2 features, 3 samples,
// 16-bit accumulator so wrap-around is reachable with 8-bit operands).
module tb_axis_linear_classifier;

  logic        ACLK;
  logic        ARESET;
  logic        MODE;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;
  logic        ERR;

  axis_linear_classifier #(
    .DATA_W   (8),
    .N_FEAT   (2),
    .N_SAMPLES(3),
    .ACC_W    (16),
    .THRESH   (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .MODE         (MODE),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .S_AXIS_TLAST (S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .ERR          (ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic            mode;
    logic [2:0][7:0] w;
    logic [5:0][7:0] x;
    logic [2:0][31:0] res;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] frameWords [9];
  logic [31:0] expResult [3];
  int          checkCount = 0;
  int          passCount  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic setVec(input int idx, input logic mode,
                        input int w0, input int w1, input int w2,
                        input int x0, input int x1, input int x2,
                        input int x3, input int x4, input int x5,
                        input int r0, input int r1, input int r2);
    vecs[idx].mode   = mode;
    vecs[idx].w[0]   = 8'(w0);
    vecs[idx].w[1]   = 8'(w1);
    vecs[idx].w[2]   = 8'(w2);
    vecs[idx].x[0]   = 8'(x0);
    vecs[idx].x[1]   = 8'(x1);
    vecs[idx].x[2]   = 8'(x2);
    vecs[idx].x[3]   = 8'(x3);
    vecs[idx].x[4]   = 8'(x4);
    vecs[idx].x[5]   = 8'(x5);
    vecs[idx].res[0] = 32'(r0);
    vecs[idx].res[1] = 32'(r1);
    vecs[idx].res[2] = 32'(r2);
  endtask

  task automatic loadVec(input int idx);
    for (int k = 0; k < 3; k++) frameWords[k] = {24'b0, vecs[idx].w[k]};
    for (int k = 0; k < 6; k++) frameWords[3 + k] = {24'b0, vecs[idx].x[k]};
    for (int k = 0; k < 3; k++) expResult[k] = vecs[idx].res[k];
    MODE = vecs[idx].mode;
  endtask

  // Offers one word and holds it until the DUT takes it, bounded by a cycle budget.
  task automatic sendWord(input logic [31:0] data, input logic last);
    int   waitCycles = 0;
    logic accepted   = 1'b0;
    S_AXIS_TDATA  = data;
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    while (!accepted && waitCycles < 20) begin
      accepted = S_AXIS_TREADY;
      @(posedge ACLK); #1;
      waitCycles++;
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    if (!accepted) checkOutput("input accept timeout", 32'(accepted), 32'd1);
  endtask

  task automatic applyStimulus(input int nWords, input int tlastAt, input bit gaps);
    for (int i = 0; i < nWords; i++) begin
      sendWord(frameWords[i], (i + 1) == tlastAt);
      if (gaps && (i % 3 == 1)) begin
        @(posedge ACLK); #1;
      end
    end
  endtask

  // Drains the three results; valid must hold back-to-back while TREADY stays high.
  task automatic checkResults(input string tag, input int stallAt, input logic expErr);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s valid%0d", tag, i), 32'(M_AXIS_TVALID), 32'd1);
      checkOutput($sformatf("%s data%0d", tag, i), M_AXIS_TDATA, expResult[i]);
      checkOutput($sformatf("%s last%0d", tag, i), 32'(M_AXIS_TLAST), 32'(i == 2));
      if (i == stallAt) begin
        M_AXIS_TREADY = 1'b0;
        repeat (5) begin
          @(posedge ACLK); #1;
          checkOutput($sformatf("%s stall data%0d", tag, i), M_AXIS_TDATA, expResult[i]);
        end
        M_AXIS_TREADY = 1'b1;
      end
      @(posedge ACLK); #1;
    end
    checkOutput({tag, " idle valid"}, 32'(M_AXIS_TVALID), 32'd0);
    checkOutput({tag, " idle data"}, M_AXIS_TDATA, 32'd0);
    checkOutput({tag, " idle sready"}, 32'(S_AXIS_TREADY), 32'd0);
    checkOutput({tag, " err"}, 32'(ERR), 32'(expErr));
  endtask

  initial begin
    ARESET        = 1'b1;
    MODE          = 1'b0;
    S_AXIS_TDATA  = 32'b0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b1;

    // Scores hand-computed, wrapped to 16 bits, then sign-extended (mode 1) or thresholded > 16 (mode 0).
    setVec(0, 1'b1,   10,   2,   -1,   5,   3,   0,   0, 100, 250,     17,     10,   -40);
    setVec(1, 1'b0,   10,   2,   -1,   5,   3,   0,   0, 100, 250,      1,      0,     0);
    setVec(2, 1'b1,  127, 127,  127, 255, 255, 255, 255, 255, 255,   -639,   -639,  -639);
    setVec(3, 1'b0,  127, 127,  127, 255, 255, 255, 255, 255, 255,      0,      0,     0);
    setVec(4, 1'b1, -128, 127, -128, 255,   0,   0, 255,   1,   1,  32257, -32768,  -129);
    setVec(5, 1'b0, -128, 127, -128, 255,   0,   0, 255,   1,   1,      1,      0,     0);
    setVec(6, 1'b0,   16,  -1,    1,   0,   0,   0,   1,   1,   0,      0,      1,     0);

    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("reset sready", 32'(S_AXIS_TREADY), 32'd0);
    checkOutput("reset mvalid", 32'(M_AXIS_TVALID), 32'd0);
    checkOutput("reset mlast", 32'(M_AXIS_TLAST), 32'd0);
    checkOutput("reset mdata", M_AXIS_TDATA, 32'd0);
    checkOutput("reset err", 32'(ERR), 32'd0);
    ARESET = 1'b0;

    for (int v = 0; v < 7; v++) begin
      loadVec(v);
      applyStimulus(9, 9, v[0]);
      checkResults($sformatf("vec%0d", v), -1, 1'b0);
    end

    // Input gaps plus a five-cycle output stall on the second result.
    loadVec(0);
    applyStimulus(9, 9, 1'b1);
    checkResults("stall", 1, 1'b0);

    // Early TLAST on word 4 aborts the frame without any output.
    loadVec(0);
    applyStimulus(4, 4, 1'b0);
    checkOutput("early err", 32'(ERR), 32'd1);
    checkOutput("early sready", 32'(S_AXIS_TREADY), 32'd0);
    repeat (4) begin
      @(posedge ACLK); #1;
      checkOutput("early no mvalid", 32'(M_AXIS_TVALID), 32'd0);
    end
    loadVec(2);
    applyStimulus(9, 9, 1'b0);
    checkResults("after early", -1, 1'b1);

    // Reset in the middle of the feature phase clears the sticky error.
    loadVec(0);
    applyStimulus(5, 0, 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checkOutput("rst readx sready", 32'(S_AXIS_TREADY), 32'd0);
    checkOutput("rst readx err", 32'(ERR), 32'd0);
    checkOutput("rst readx mvalid", 32'(M_AXIS_TVALID), 32'd0);
    ARESET = 1'b0;

    // Reset after one result has been taken; the next frame must start at result 0.
    loadVec(4);
    applyStimulus(9, 9, 1'b0);
    checkOutput("pre rst write data", M_AXIS_TDATA, expResult[0]);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checkOutput("rst write mvalid", 32'(M_AXIS_TVALID), 32'd0);
    checkOutput("rst write mlast", 32'(M_AXIS_TLAST), 32'd0);
    checkOutput("rst write mdata", M_AXIS_TDATA, 32'd0);
    checkOutput("rst write sready", 32'(S_AXIS_TREADY), 32'd0);
    ARESET = 1'b0;
    loadVec(0);
    applyStimulus(9, 9, 1'b0);
    checkResults("after rst", -1, 1'b0);

    // Missing TLAST on the final word flags ERR but the results still come out.
    loadVec(6);
    applyStimulus(9, 0, 1'b0);
    checkResults("no tlast", -1, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axis_linear_classifier.md
# axis_linear_classifier

Parametrised AXI-Stream linear-classifier coprocessor, the next-generation replacement for the fixed 8-bit, 64-sample inference IP.
- It accepts one frame per inference on the slave stream: a weight vector (bias first), then N_SAMPLES feature vectors.
- It multiply-accumulates each sample on the fly and buffers one result per sample.
- It then streams the results on the master stream, either as class bits or as raw scores.
- It sits between the DMA MM2S and S2MM channels.

## Interface
Parameters:
- DATA_W, 8: significant bits per input word (low bits of TDATA). Weights are signed, features unsigned.
- N_FEAT, 7: features per sample, excluding the bias.
- N_SAMPLES, 64: samples per frame; also the depth of the result buffer.
- ACC_W, 24: accumulator width, signed, ≤ 32.
- THRESH, 128: class threshold. The class bit is 1 iff score > THRESH (signed compare).

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  synchronous reset, active-high.
- MODE  in  1  output mode: 0 = class bit, 1 = raw score. Captured on the IDLE→READ_W transition.
- S_AXIS_TREADY  out  1  ready to accept input.
- S_AXIS_TDATA  in  32  input word; bits [DATA_W-1:0] are used.
- S_AXIS_TLAST  in  1  marks the final word of the frame.
- S_AXIS_TVALID  in  1  input valid.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TDATA  out  32  result word.
- M_AXIS_TLAST  out  1  marks the final result.
- M_AXIS_TREADY  in  1  downstream ready.
- ERR  out  1  sticky framing error; cleared only by ARESET.

## Operation
Frame layout:
- N_FEAT+1 weight words: w0 (bias), then w1..wN.
- Then N_SAMPLES×N_FEAT feature words, sample-major.
- Total frame length L = N_FEAT+1 + N_SAMPLES×N_FEAT.

States (one-hot) and transitions:
- IDLE: on S_AXIS_TVALID, go to READ_W and capture MODE. No word is consumed in IDLE.
- READ_W: store each accepted word into weight register wi. After w_N is accepted, go to READ_X. The accumulator is loaded with sign-extended w0 when w0 is accepted.
- READ_X: on each accepted feature x_j, acc ← acc + w_j·x_j.
  - On the last feature of a sample, write acc + w_N·x_N to result[sample] and reload acc with w0.
  - After the last sample, go to WRITE.
- WRITE: present result[rd_ptr]. On TVALID&TREADY, increment rd_ptr. After index N_SAMPLES-1 is accepted, go to IDLE and clear the pointers.

Arithmetic:
- Product is signed(DATA_W+1) × signed DATA_W; accumulation wraps two's-complement modulo 2^ACC_W.
- MODE 0: M_AXIS_TDATA = {31'b0, score > THRESH}.
- MODE 1: M_AXIS_TDATA = score sign-extended to 32 bits.

Framing:
- S_AXIS_TLAST asserted before word L is an early-TLAST error: set ERR, discard the partial frame, and return to IDLE on the next cycle. No output is produced.
- TLAST absent on word L: set ERR, but the frame completes and is output normally.

## Timing
Reset values:
- State is IDLE.
- S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST and ERR are 0.
- M_AXIS_TDATA is 0. It is forced to 0 whenever M_AXIS_TVALID = 0.
- Counters and acc are 0.

Handshakes:
- S_AXIS_TREADY = 1 exactly in READ_W and READ_X. A word transfers on TVALID&TREADY only; TVALID gaps stall without state change.
- M_AXIS_TVALID = 1 exactly in WRITE. Data is held stable while TREADY = 0.
- M_AXIS_TLAST = M_AXIS_TVALID & (rd_ptr == N_SAMPLES-1).

Latency:
- The first input word is accepted no earlier than 1 cycle after TVALID is seen in IDLE.
- M_AXIS_TVALID rises the cycle after word L is accepted.
- With TREADY held high, output throughput is 1 word/cycle.
- IDLE is re-entered the cycle after the final output is accepted; a new frame may start from there.

Other rules:
- ARESET mid-frame or mid-output aborts immediately to reset values; buffered results are invalidated.
- The result buffer is written only in READ_X and read only in WRITE, so there is no read/write collision.

## Structure
Package clf_pkg holds:
- the one-hot state encoding;
- localparams L, the weight count and the pointer widths ($clog2(N_SAMPLES), $clog2(N_FEAT+1));
- the score-to-TDATA formatting function.

Sub-module clf_result_buf is a simple dual-port register array: N_SAMPLES × ACC_W, synchronous write, combinational read. The FSM, weight registers and MAC stay in the top level.

## Test plan
1. N_FEAT=2, N_SAMPLES=3, MODE=1, weights {10,2,-1}, features {(5,3),(0,0),(100,250)} with TLAST on word 9 → outputs 17, 10, -40 (0xFFFFFFD8); TLAST on the third output; ERR=0.
2. Same frame with MODE=0, THRESH=16 → outputs 1, 0, 0.
3. Default parameters, random frame; S_AXIS_TVALID toggled pseudo-randomly and M_AXIS_TREADY low for 5 cycles mid-output → 64 results match the reference model; TDATA stable across stalls.
4. TLAST on word 4 of a 9-word frame → ERR=1, no M_AXIS_TVALID; the next clean frame still produces correct results.
5. ARESET pulsed during READ_X and again during WRITE → all outputs return to reset values the next cycle; a following frame is correct.
6. Overflow: ACC_W=16, DATA_W=8, weights 127, features 255, N_FEAT=7 → score wraps modulo 2^16 and matches the model bit-exactly.
